// File: rtl/gearbox_66_20_sched.sv
// Transmit-side scheduler for the 66:20 gearbox: buffers encoder blocks, feeds the
// gearbox din register on each ack, sequences gearbox reset and watches ack cadence.
module gearbox_66_20_sched #(
  parameter int          DEPTH             = 4,
  parameter logic [65:0] IDLE_BLOCK        = 66'h79,
  parameter int          SCLR_CYCLES       = 4,
  parameter int          FIRST_ACK_TIMEOUT = 8,
  parameter int          LOCK_ACKS         = 10
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic [65:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [65:0] gb_din,
  input  logic        gb_din_ack,
  output logic        gb_sclr,
  output logic        idle_ins,
  output logic [15:0] idle_cnt,
  output logic        cadence_err,
  output logic        locked,
  output logic [1:0]  dbg_state
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW  = AW + 1;
  localparam int GMAX0 = (SCLR_CYCLES > FIRST_ACK_TIMEOUT) ? SCLR_CYCLES : FIRST_ACK_TIMEOUT;
  localparam int GMAX  = (GMAX0 > 5) ? GMAX0 : 5;
  localparam int GW    = $clog2(GMAX + 1);
  localparam int LW    = $clog2(LOCK_ACKS + 1);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [LW-1:0]     ack_cnt_q;
  logic [65:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]   count_q;
  logic [65:0]       gb_din_q;
  logic              idle_ins_q;
  logic [15:0]       idle_cnt_q;
  logic              cadence_err_q;

  logic take;   // ack accepted: gb_din advances this edge
  logic fault;  // cadence violation detected this edge
  logic push, pop;

  // State register
  always_ff @(posedge clk) begin
    if (sclr) state_q <= ST_RST;
    else      state_q <= state_d;
  end

  // Next-state logic; gap_q doubles as the reset-pulse timer, first-ack timer and ack gap
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    fault   = 1'b0;
    case (state_q)
      ST_RST: begin
        if (gap_q == GW'(SCLR_CYCLES - 1)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (gb_din_ack) begin
          take    = 1'b1;
          state_d = ST_RUN;
        end else if (gap_q == GW'(FIRST_ACK_TIMEOUT - 1)) begin
          fault   = 1'b1;
          state_d = ST_RST;
        end
      end
      ST_RUN: begin
        if (gb_din_ack) begin
          if (gap_q < GW'(3)) begin
            fault   = 1'b1;
            state_d = ST_RST;
          end else begin
            take = 1'b1;
          end
        end else if (gap_q == GW'(4)) begin
          fault   = 1'b1;
          state_d = ST_RST;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // Outputs. Handshake: a block transfers on every clk edge where in_valid && in_ready;
  // in_ready depends only on registered state and never on in_valid or gb_din_ack.
  always_comb begin
    gb_sclr   = (state_q == ST_RST);
    in_ready  = (count_q < CNTW'(DEPTH)) && (state_q != ST_RST);
    dbg_state = state_q;
  end

  assign push = in_valid && in_ready;
  assign pop  = take && (count_q != '0);

  always_comb begin
    gap_d = gap_q + GW'(1);
    if (fault || (state_q == ST_RST && state_d == ST_WAIT)) gap_d = '0;
    else if (take)                                          gap_d = GW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      gap_q         <= '0;
      ack_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      gb_din_q      <= IDLE_BLOCK;
      idle_ins_q    <= 1'b0;
      idle_cnt_q    <= '0;
      cadence_err_q <= 1'b0;
    end else begin
      gap_q      <= gap_d;
      idle_ins_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
      if (fault) begin
        cadence_err_q <= 1'b1;
        ack_cnt_q     <= '0;
        gb_din_q      <= IDLE_BLOCK;
      end else if (take) begin
        // The first ack after WAIT has no gap to judge, so only RUN acks count toward lock
        if (state_q == ST_RUN && ack_cnt_q != LW'(LOCK_ACKS)) ack_cnt_q <= ack_cnt_q + LW'(1);
        if (pop) begin
          gb_din_q <= mem_q[rd_ptr_q];
        end else begin
          gb_din_q   <= IDLE_BLOCK;
          idle_ins_q <= 1'b1;
          if (idle_cnt_q != 16'hFFFF) idle_cnt_q <= idle_cnt_q + 16'd1;
        end
      end
    end
  end

  assign gb_din      = gb_din_q;
  assign idle_ins    = idle_ins_q;
  assign idle_cnt    = idle_cnt_q;
  assign cadence_err = cadence_err_q;
  assign locked      = (ack_cnt_q == LW'(LOCK_ACKS));

endmodule

// File: tb/tb_gearbox_66_20_sched.sv
// Bench for gearbox_66_20_sched: directed startup, streaming, underflow, cadence faults
// and mid-run reset, with a transaction-level model compared every cycle.
module tb_gearbox_66_20_sched;

  localparam logic [65:0] IDLE = 66'h79;
  localparam int DEPTH     = 4;
  localparam int SCLR_CYC  = 4;
  localparam int TIMEOUT   = 8;
  localparam int LOCK_ACKS = 10;
  localparam int PH_HOLD = 0, PH_WAIT = 1, PH_RUN = 2;

  logic        clk;
  logic        sclr;
  logic [65:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [65:0] gb_din;
  logic        gb_din_ack;
  logic        gb_sclr;
  logic        idle_ins;
  logic [15:0] idle_cnt;
  logic        cadence_err;
  logic        locked;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  gearbox_66_20_sched #(
    .DEPTH(DEPTH), .IDLE_BLOCK(IDLE), .SCLR_CYCLES(SCLR_CYC),
    .FIRST_ACK_TIMEOUT(TIMEOUT), .LOCK_ACKS(LOCK_ACKS)
  ) dut (
    .clk(clk), .sclr(sclr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .gb_din(gb_din), .gb_din_ack(gb_din_ack), .gb_sclr(gb_sclr), .idle_ins(idle_ins),
    .idle_cnt(idle_cnt), .cadence_err(cadence_err), .locked(locked), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO as a queue plus timers measured in edges since the last relevant event
  logic [65:0] m_q[$];
  logic [65:0] m_din;
  bit          m_idle_ins, m_err, m_valid = 1'b0;
  int          m_idle_cnt, m_legal, m_phase, m_hold, m_wait, m_since;

  function automatic bit m_in_ready();
    return (m_q.size() < DEPTH) && (m_phase != PH_HOLD);
  endfunction

  always @(posedge clk) begin : model
    bit push, take, fault;
    int d;
    if (sclr) begin
      m_q.delete();
      m_din = IDLE; m_idle_ins = 0; m_idle_cnt = 0; m_err = 0; m_legal = 0;
      m_phase = PH_HOLD; m_hold = 0; m_wait = 0; m_since = 0; m_valid = 1;
    end else if (m_valid) begin
      push = in_valid && m_in_ready();
      take = 0; fault = 0; m_idle_ins = 0;
      case (m_phase)
        PH_HOLD: begin
          m_hold++;
          if (m_hold == SCLR_CYC) begin m_phase = PH_WAIT; m_wait = 0; end
        end
        PH_WAIT: begin
          if (gb_din_ack) begin take = 1; m_phase = PH_RUN; m_since = 0; end
          else begin m_wait++; if (m_wait == TIMEOUT) fault = 1; end
        end
        default: begin
          d = m_since + 1;
          if (gb_din_ack) begin
            if (d < 3) fault = 1;
            else begin take = 1; m_since = 0; if (m_legal < LOCK_ACKS) m_legal++; end
          end else if (d >= 4) fault = 1;
          else m_since = d;
        end
      endcase
      if (fault) begin
        m_err = 1; m_legal = 0; m_phase = PH_HOLD; m_hold = 0; m_din = IDLE;
      end
      if (take) begin
        if (m_q.size() > 0) m_din = m_q.pop_front();
        else begin
          m_din = IDLE; m_idle_ins = 1;
          if (m_idle_cnt < 65535) m_idle_cnt++;
        end
      end
      if (push) m_q.push_back(in_data);
    end
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_in_ready", in_ready, m_in_ready());
      chk("m_gb_din", gb_din, m_din);
      chk("m_gb_sclr", gb_sclr, m_phase == PH_HOLD);
      chk("m_idle_ins", idle_ins, m_idle_ins);
      chk("m_idle_cnt", idle_cnt, 66'(m_idle_cnt));
      chk("m_cadence_err", cadence_err, m_err);
      chk("m_locked", locked, m_legal == LOCK_ACKS);
    end
  end

  // Driver tasks
  int gaps[4] = '{3, 3, 3, 4};
  int cad_idx, cad_since;
  bit last_ack;

  task automatic tick(input bit a);
    gb_din_ack = a;
    @(posedge clk);
    #1;
    gb_din_ack = 1'b0;
  endtask

  task automatic cad_tick();
    int d;
    d = cad_since + 1;
    last_ack = (d == gaps[cad_idx]);
    if (last_ack) begin cad_since = 0; cad_idx = (cad_idx + 1) % 4; end
    else cad_since = d;
    tick(last_ack);
  endtask

  task automatic count_sclr(output int n);
    n = 0;
    while (gb_sclr === 1'b1 && n < 20) begin n++; tick(1'b0); end
  endtask

  initial begin
    int n, nacks, g, k, rx, p, pulses;
    bit full_seen, pushed;
    logic [65:0] exp3 [7];
    sclr = 1'b1; in_valid = 1'b0; in_data = '0; gb_din_ack = 1'b0;
    cad_idx = 0; cad_since = 0; last_ack = 0;

    // Startup sequencing and lock
    repeat (3) @(posedge clk);
    #1 sclr = 1'b0;
    chk("rst_gb_din", gb_din, IDLE);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_idle_cnt", idle_cnt, 0);
    chk("rst_locked", locked, 0);
    count_sclr(n);
    chk("startup_sclr_len", n, 4);
    chk("wait_gb_din", gb_din, IDLE);
    tick(0); tick(0); tick(1);
    chk("first_ack_idle_cnt", idle_cnt, 1);
    nacks = 0; g = 0;
    while (nacks < 10 && g < 200) begin
      cad_tick(); g++;
      if (last_ack) begin
        nacks++;
        if (nacks == 9)  chk("lock_early", locked, 0);
        if (nacks == 10) chk("lock_after_10", locked, 1);
      end
    end
    chk("lock_acks_seen", nacks, 10);
    chk("startup_idle_cnt", idle_cnt, 11);
    chk("startup_cadence_err", cadence_err, 0);

    // Continuous data 1..20 at full rate
    k = 1; rx = 0; g = 0; full_seen = 0;
    while (rx < 20 && g < 400) begin
      in_valid = (k <= 20);
      in_data  = 66'(k);
      if (in_valid && !in_ready) full_seen = 1;
      pushed = in_valid && in_ready;
      cad_tick(); g++;
      if (pushed) k++;
      if (last_ack) begin rx++; chk("stream_order", gb_din, 66'(rx)); end
    end
    in_valid = 1'b0;
    chk("stream_count", rx, 20);
    chk("stream_full_seen", full_seen, 1);
    chk("stream_idle_cnt", idle_cnt, 11);

    // Underflow after two blocks
    exp3[0] = 66'h100; exp3[1] = 66'h101;
    for (int i = 2; i < 7; i++) exp3[i] = IDLE;
    p = 0; rx = 0; g = 0; pulses = 0;
    while (rx < 7 && g < 100) begin
      in_valid = (p < 2);
      in_data  = 66'h100 + 66'(p);
      pushed = in_valid && in_ready;
      cad_tick(); g++;
      if (pushed) p++;
      if (idle_ins) pulses++;
      if (last_ack) begin chk("underflow_seq", gb_din, exp3[rx]); rx++; end
    end
    in_valid = 1'b0;
    chk("underflow_acks", rx, 7);
    chk("underflow_pulses", pulses, 5);
    chk("underflow_idle_cnt", idle_cnt, 16);

    // Cadence fault: gap of 2
    chk("locked_before_fault", locked, 1);
    tick(0); tick(1);
    chk("gap2_err", cadence_err, 1);
    chk("gap2_locked", locked, 0);
    chk("gap2_sclr", gb_sclr, 1);
    chk("gap2_gb_din", gb_din, IDLE);
    count_sclr(n);
    chk("gap2_sclr_len", n, 4);
    tick(0); tick(1);
    cad_idx = 0; cad_since = 0; nacks = 0; g = 0;
    while (nacks < 3 && g < 50) begin cad_tick(); g++; if (last_ack) nacks++; end

    // Cadence fault: ack missing in RUN
    tick(0); tick(0); tick(0);
    chk("no_ack_still_run", gb_sclr, 0);
    tick(0);
    chk("no_ack_fault_sclr", gb_sclr, 1);
    chk("no_ack_locked", locked, 0);
    count_sclr(n);
    chk("no_ack_sclr_len", n, 4);

    // Cadence fault: first ack never arrives
    n = 0;
    while (gb_sclr === 1'b0 && n < 20) begin tick(0); n++; end
    chk("timeout_len", n, 8);
    chk("timeout_err", cadence_err, 1);
    count_sclr(n);
    chk("timeout_sclr_len", n, 4);

    // Mid-operation reset with three blocks queued
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 66'h300 + 66'(i); tick(0); end
    in_valid = 1'b0;
    sclr = 1'b1;
    tick(0);
    sclr = 1'b0;
    chk("midrst_gb_din", gb_din, IDLE);
    chk("midrst_idle_cnt", idle_cnt, 0);
    chk("midrst_err", cadence_err, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_in_ready", in_ready, 0);
    count_sclr(n);
    chk("midrst_sclr_len", n, 4);
    tick(1);
    chk("midrst_first_ack_din", gb_din, IDLE);
    chk("midrst_first_ack_idle", idle_cnt, 1);
    tick(0); tick(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
